// File: rtl/axi_wdata_drain_if.sv
// Bundle of the command, FIFO-read and AXI4 W channel signals used by
// axi_wdata_drain. The slave modport is the drain's view; the master modport
// is the view of whatever drives commands, owns the FIFO and sinks W beats.
interface axi_wdata_drain_if #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int LGFLEN           = 4
);
  localparam int SW = C_AXI_DATA_WIDTH / 8;

  // command
  logic                        i_cmd_valid;
  logic                        o_cmd_ready;
  logic [7:0]                  i_cmd_len;
  logic [SW-1:0]               i_cmd_last_strb;
  // FIFO read side
  logic                        o_fifo_rd;
  logic [C_AXI_DATA_WIDTH-1:0] i_fifo_data;
  logic                        i_fifo_empty;
  logic [LGFLEN:0]             i_fifo_fill;
  // AXI W channel
  logic                        o_wvalid;
  logic                        i_wready;
  logic [C_AXI_DATA_WIDTH-1:0] o_wdata;
  logic [SW-1:0]               o_wstrb;
  logic                        o_wlast;
  // status
  logic                        o_busy;
  logic                        o_done;

  modport slave (
    input  i_cmd_valid, i_cmd_len, i_cmd_last_strb,
    input  i_fifo_data, i_fifo_empty, i_fifo_fill,
    input  i_wready,
    output o_cmd_ready, o_fifo_rd,
    output o_wvalid, o_wdata, o_wstrb, o_wlast,
    output o_busy, o_done
  );

  modport master (
    output i_cmd_valid, i_cmd_len, i_cmd_last_strb,
    output i_fifo_data, i_fifo_empty, i_fifo_fill,
    output i_wready,
    input  o_cmd_ready, o_fifo_rd,
    input  o_wvalid, o_wdata, o_wstrb, o_wlast,
    input  o_busy, o_done
  );
endinterface

// File: rtl/axi_wdata_drain.sv
// axi_wdata_drain: pops one burst worth of words from the write-data FIFO and
// drives them onto the AXI4 W channel through a registered output stage.
// Optional macro AXI_WDRAIN_WHOLE_BURST_EN compiles in a WAIT state that holds
// the burst back until the FIFO holds the whole burst (or is full), giving
// bubble-free W beats for bursts that fit in the FIFO.
module axi_wdata_drain #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int LGFLEN           = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  axi_wdata_drain_if.slave   bus
);
  localparam int SW    = C_AXI_DATA_WIDTH / 8;
  localparam int DEPTH = 1 << LGFLEN;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [8:0]                  cnt_q, cnt_d;          // beats still to load, 1..256
  logic [SW-1:0]               last_strb_q, last_strb_d;
  logic                        done_q, done_d;

  logic                        wvalid_q;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]               wstrb_q;
  logic                        wlast_q;

  logic                        load;
  logic                        w_hs;

  assign w_hs = wvalid_q && bus.i_wready;

`ifdef AXI_WDRAIN_WHOLE_BURST_EN
  // The counter still holds len+1 while waiting, so it doubles as the burst
  // size for the fill threshold; clamp to the FIFO depth for long bursts.
  logic [8:0] fill_9;
  logic [8:0] thresh;
  assign fill_9 = 9'(bus.i_fifo_fill);
  assign thresh = (cnt_q > 9'(DEPTH)) ? 9'(DEPTH) : cnt_q;
`else
  logic unused_fill;
  assign unused_fill = ^bus.i_fifo_fill;
`endif

  // Next-state logic: command capture, optional fill wait, beat loading.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_strb_d = last_strb_q;
    done_d      = 1'b0;
    load        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_cmd_valid) begin
          cnt_d       = {1'b0, bus.i_cmd_len} + 9'd1;
          last_strb_d = bus.i_cmd_last_strb;
`ifdef AXI_WDRAIN_WHOLE_BURST_EN
          state_d     = S_WAIT;
`else
          state_d     = S_BURST;
`endif
        end
      end
`ifdef AXI_WDRAIN_WHOLE_BURST_EN
      S_WAIT: begin
        if (fill_9 >= thresh) state_d = S_BURST;
      end
`endif
      S_BURST: begin
        // Load the output register whenever it is empty or being drained.
        load = (cnt_q != 9'd0) && !bus.i_fifo_empty && (!wvalid_q || bus.i_wready);
        if (load) cnt_d = cnt_q - 9'd1;
        // The final beat was loaded with cnt==1, so cnt is already 0 here
        // and no load can coincide with the last handshake.
        if (w_hs && wlast_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 9'd0;
      last_strb_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_strb_q <= last_strb_d;
      done_q      <= done_d;
    end
  end

  // W output stage: holds its beat until accepted, refills on every load.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wvalid_q <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wlast_q  <= 1'b0;
    end else if (load) begin
      wvalid_q <= 1'b1;
      wdata_q  <= bus.i_fifo_data;
      wlast_q  <= (cnt_q == 9'd1);
      wstrb_q  <= (cnt_q == 9'd1) ? last_strb_q : {SW{1'b1}};
    end else if (w_hs) begin
      wvalid_q <= 1'b0;
    end
  end

  assign bus.o_cmd_ready = (state_q == S_IDLE);
  assign bus.o_busy      = (state_q != S_IDLE);
  assign bus.o_done      = done_q;
  assign bus.o_fifo_rd   = load;
  assign bus.o_wvalid    = wvalid_q;
  assign bus.o_wdata     = wdata_q;
  assign bus.o_wstrb     = wstrb_q;
  assign bus.o_wlast     = wlast_q;
endmodule

// File: tb/tb_axi_wdata_drain.sv
// Bench for axi_wdata_drain: a depth-limited FIFO model feeds the DUT, the
// driver issues commands and pushes expected beats, and a monitor scores
// every W handshake, pop and done pulse against those expectations.
`timescale 1ns/1ps
module tb_axi_wdata_drain;
  localparam int DW     = 32;
  localparam int LGFLEN = 4;
  localparam int SW     = DW / 8;
  localparam int DEPTH  = 1 << LGFLEN;
`ifdef AXI_WDRAIN_WHOLE_BURST_EN
  localparam int WAIT_LAT = 1;
`else
  localparam int WAIT_LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_wdata_drain_if #(.C_AXI_DATA_WIDTH(DW), .LGFLEN(LGFLEN)) bus ();
  axi_wdata_drain #(.C_AXI_DATA_WIDTH(DW), .LGFLEN(LGFLEN)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct packed {
    logic [SW-1:0] strb;
    logic          last;
  } beat_t;

  // Words handed to the FIFO, in order (driver writes, fifo model and monitor read).
  logic [DW-1:0] word_mem [0:4095];
  int            word_wr = 0;
  // Expected strobe/last per beat (driver writes, monitor reads).
  beat_t         exp_mem  [0:4095];
  int            exp_wr = 0;
  int            cmds_sent = 0;
  // Reset flush: the driver bumps epoch and the readers skip to these indices.
  int            epoch = 0, skip_word = 0, skip_exp = 0, skip_done = 0;

  int            checks = 0, failures = 0;
  int            cyc = 0;
  int            accept_cyc = 0;
  int            wr_mode = 0;   // 0: wready high, 1: random, 2: wready low

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- FIFO model (depth DEPTH, backlog in word_mem) ----------
  logic [DW-1:0] mem_q [$];
  int            push_rd = 0, f_epoch = 0, pops = 0;
  logic          rd_seen;
  initial begin
    bus.i_fifo_empty = 1'b1;
    bus.i_fifo_fill  = '0;
    bus.i_fifo_data  = '0;
    forever begin
      @(negedge clk);
      if (f_epoch != epoch) begin
        mem_q.delete();
        push_rd = skip_word;
        f_epoch = epoch;
      end
      rd_seen = bus.o_fifo_rd;
      @(posedge clk);
      #1;
      if (rd_seen && mem_q.size() != 0) begin
        void'(mem_q.pop_front());
        pops++;
      end
      while (push_rd < word_wr && mem_q.size() < DEPTH) begin
        mem_q.push_back(word_mem[push_rd]);
        push_rd++;
      end
      bus.i_fifo_empty = (mem_q.size() == 0);
      bus.i_fifo_fill  = (LGFLEN+1)'(mem_q.size());
      bus.i_fifo_data  = (mem_q.size() != 0) ? mem_q[0] : '0;
    end
  end

  // ---------------- W ready generator --------------------------------------
  initial begin
    bus.i_wready = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      case (wr_mode)
        0:       bus.i_wready = 1'b1;
        1:       bus.i_wready = 1'($urandom_range(0, 1));
        default: bus.i_wready = 1'b0;
      endcase
    end
  end

  // ---------------- Monitor / scoreboard ----------------------------------
  int            exp_rd = 0, data_rd = 0, dones_seen = 0, m_epoch = 0;
  int            beats = 0, beat_idx = 0, first_hs_cyc = 0, last_done_cyc = 0;
  logic          last_hs_prev = 1'b0, have_hold = 1'b0;
  logic [DW+SW:0] held_beat = '0;
  beat_t         eb;

  always @(negedge clk) begin
    if (m_epoch != epoch) begin
      exp_rd       = skip_exp;
      data_rd      = skip_word;
      dones_seen   = skip_done;
      m_epoch      = epoch;
      beat_idx     = 0;
      last_hs_prev = 1'b0;
      have_hold    = 1'b0;
    end
    if (rst) begin
      last_hs_prev = 1'b0;
      have_hold    = 1'b0;
    end else begin
      if (bus.o_fifo_rd) chk("pop_when_empty", bus.i_fifo_empty, 1'b0);
      if (have_hold) begin
        chk("hold_wvalid", bus.o_wvalid, 1'b1);
        chk("hold_stable", {bus.o_wdata, bus.o_wstrb, bus.o_wlast}, held_beat);
      end
      if (last_hs_prev || bus.o_done) chk("done_pulse", bus.o_done, last_hs_prev);
      if (bus.o_done) begin
        dones_seen++;
        last_done_cyc = cyc;
      end
      last_hs_prev = 1'b0;
      if (bus.o_wvalid && bus.i_wready) begin
        if (exp_rd >= exp_wr) begin
          chk("unexpected_beat", 1'b1, 1'b0);
        end else begin
          eb = exp_mem[exp_rd];
          chk("beat_data", bus.o_wdata, word_mem[data_rd]);
          chk("beat_strb", bus.o_wstrb, eb.strb);
          chk("beat_last", bus.o_wlast, eb.last);
          exp_rd++;
          data_rd++;
        end
        if (beat_idx == 0) first_hs_cyc = cyc;
        beat_idx     = bus.o_wlast ? 0 : beat_idx + 1;
        beats++;
        last_hs_prev = bus.o_wlast;
      end
      have_hold = bus.o_wvalid && !bus.i_wready;
      held_beat = {bus.o_wdata, bus.o_wstrb, bus.o_wlast};
    end
  end

  // ---------------- Driver -------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic feed_word(input logic [DW-1:0] w);
    word_mem[word_wr] = w;
    word_wr++;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) feed_word($urandom);
  endtask

  task automatic send_cmd(input int len, input logic [SW-1:0] strb);
    int t;
    t = 0;
    while (!bus.o_cmd_ready && t < 2000) begin
      tick(1);
      t++;
    end
    if (t >= 2000) chk("cmd_ready_timeout", 1'b1, 1'b0);
    for (int i = 0; i <= len; i++) begin
      exp_mem[exp_wr] = '{strb: (i == len) ? strb : {SW{1'b1}}, last: (i == len)};
      exp_wr++;
    end
    cmds_sent++;
    bus.i_cmd_valid     = 1'b1;
    bus.i_cmd_len       = 8'(len);
    bus.i_cmd_last_strb = strb;
    tick(1);
    accept_cyc          = cyc;
    bus.i_cmd_valid     = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((dones_seen != cmds_sent || exp_rd != exp_wr) && t < 4000) begin
      tick(1);
      t++;
    end
    if (t >= 4000) chk(name, 1'b1, 1'b0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cmd_ready"}, bus.o_cmd_ready, 1'b1);
    chk({tag, "_busy"},      bus.o_busy,      1'b0);
    chk({tag, "_done"},      bus.o_done,      1'b0);
    chk({tag, "_fifo_rd"},   bus.o_fifo_rd,   1'b0);
    chk({tag, "_wvalid"},    bus.o_wvalid,    1'b0);
    chk({tag, "_wlast"},     bus.o_wlast,     1'b0);
    chk({tag, "_wdata"},     bus.o_wdata,     '0);
    chk({tag, "_wstrb"},     bus.o_wstrb,     '0);
  endtask

  initial begin
    int p0, b0, t, len, pre;
    logic [SW-1:0] strb;
    bus.i_cmd_valid     = 1'b0;
    bus.i_cmd_len       = '0;
    bus.i_cmd_last_strb = '0;
    rst                 = 1'b1;
    tick(3);
    chk_reset_values("rst0");
    rst = 1'b0;
    tick(1);

    // 1: four beats from a preloaded FIFO, ready held high
    wr_mode = 0;
    p0 = pops;
    feed_word(32'hA0); feed_word(32'hA1); feed_word(32'hA2); feed_word(32'hA3);
    tick(2);
    send_cmd(3, 4'h3);
    wait_idle("t1_timeout");
    chk("t1_first_beat_latency", first_hs_cyc - accept_cyc, 1 + WAIT_LAT);
    chk("t1_done_latency", last_done_cyc - accept_cyc, 5 + WAIT_LAT);
    chk("t1_back_to_back", last_done_cyc - first_hs_cyc, 4);
    chk("t1_pops", pops - p0, 4);

    // 2: single beat held under backpressure
    wr_mode = 2;
    feed(1);
    tick(2);
    send_cmd(0, 4'h5);
    tick(4);
    chk("t2_wvalid_held", bus.o_wvalid, 1'b1);
    chk("t2_wlast", bus.o_wlast, 1'b1);
    chk("t2_wstrb", bus.o_wstrb, 4'h5);
    wr_mode = 0;
    wait_idle("t2_timeout");

    // 3: FIFO underflow mid-burst, refill later
    p0 = pops;
    feed(3);
    tick(2);
    send_cmd(7, 4'hC);
    tick(6);
    chk("t3_pops_before_refill", pops - p0, (WAIT_LAT != 0) ? 0 : 3);
    chk("t3_wvalid_gap", bus.o_wvalid, 1'b0);
    feed(5);
    wait_idle("t3_timeout");
    chk("t3_pops_total", pops - p0, 8);

    // 4: 256-beat burst under random backpressure
    wr_mode = 1;
    p0 = pops;
    feed(256);
    send_cmd(255, 4'h1);
    wait_idle("t4_timeout");
    chk("t4_pops", pops - p0, 256);
    wr_mode = 0;

    // 5: reset after the second beat of eight, then a fresh burst
    feed(8);
    tick(2);
    b0 = beats;
    send_cmd(7, 4'hF);
    t = 0;
    while (beats - b0 < 2 && t < 200) begin
      tick(1);
      t++;
    end
    chk("t5_two_beats_seen", (beats - b0 >= 2), 1'b1);
    rst       = 1'b1;
    skip_word = word_wr;
    skip_exp  = exp_wr;
    skip_done = cmds_sent;
    epoch++;
    #1;
    chk_reset_values("rst_mid");
    tick(2);
    p0 = pops;
    tick(2);
    chk("t5_no_pop_in_reset", pops - p0, 0);
    rst = 1'b0;
    tick(1);
    p0 = pops;
    feed(2);
    send_cmd(1, 4'h6);
    wait_idle("t5_timeout");
    chk("t5_fresh_pops", pops - p0, 2);

    // 6: random bursts, random backpressure, data arriving in two parts
    for (int k = 0; k < 12; k++) begin
      len     = $urandom_range(0, 40);
      strb    = SW'($urandom);
      wr_mode = $urandom_range(0, 1);
      pre     = $urandom_range(0, len + 1);
      p0      = pops;
      feed(pre);
      send_cmd(len, strb);
      tick($urandom_range(0, 6));
      feed(len + 1 - pre);
      wait_idle("t6_timeout");
      chk("t6_pops", pops - p0, len + 1);
    end
    wr_mode = 0;

`ifdef AXI_WDRAIN_WHOLE_BURST_EN
    // 7: burst held back until the FIFO holds it all, or is full
    p0 = pops;
    send_cmd(3, 4'h9);
    for (int k = 0; k < 3; k++) begin
      feed(1);
      tick(3);
      chk("wb_no_pop_short", pops - p0, 0);
    end
    feed(1);
    wait_idle("wb_short_timeout");
    chk("wb_back_to_back", last_done_cyc - first_hs_cyc, 4);
    p0 = pops;
    send_cmd(31, 4'h2);
    feed(15);
    tick(5);
    chk("wb_no_pop_long", pops - p0, 0);
    feed(17);
    wait_idle("wb_long_timeout");
    chk("wb_long_pops", pops - p0, 32);
`endif

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
